// File: rtl/load_store_unit.sv
// Load/store initiator for a word-indexed data memory: byte/halfword/word accesses,
// read-modify-write for sub-word stores, sign/zero extension on loads.
module load_store_unit #(
  parameter int MEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        Ready,
  output logic        Done,
  output logic        Err,
  output logic [31:0] RData,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHK    = 3'd1,
    S_RD     = 3'd2,
    S_RMW_RD = 3'd3,
    S_WR     = 3'd4,
    S_FIN    = 3'd5
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q, state_d;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q, merge_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        bad_req;
  logic [4:0]  lane_shift;
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign accept     = (state_q == S_IDLE) && Req;
  assign lane_shift = {addr_q[1:0], 3'b000};

  assign bad_req = (size_q == 2'b11)
                || ((size_q == SZ_HALF) && addr_q[0])
                || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))
                || (addr_q[31:2] >= 30'(MEM_WORDS));

  // Little-endian lane select; a halfword is aligned, so 8*a equals 16*a[1].
  assign rd_shifted = ReadData >> lane_shift;

  always_comb begin
    load_ext = ReadData;
    case (size_q)
      SZ_BYTE: load_ext = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
      SZ_HALF: load_ext = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = ReadData;
    endcase
  end

  assign lane_mask = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
  assign merged    = (ReadData & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          state_d = S_CHK;
          err_d   = 1'b0;
        end
      end
      S_CHK: begin
        if (bad_req) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (!write_q) begin
          state_d = S_RD;
        end else if (size_q == SZ_WORD) begin
          state_d = S_WR;
        end else begin
          state_d = S_RMW_RD;
        end
      end
      S_RD: begin
        rdata_d = load_ext;
        state_d = S_FIN;
      end
      S_RMW_RD: begin
        merge_d = merged;
        state_d = S_WR;
      end
      S_WR:    state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        write_q  <= ReqWrite;
        size_q   <= ReqSize;
        signed_q <= ReqSigned;
        addr_q   <= ReqAddr;
        wdata_q  <= ReqWData;
      end
    end
  end

  // Write strobe is gated by Reset so an aborted store never reaches memory.
  assign Ready     = (state_q == S_IDLE);
  assign Done      = (state_q == S_FIN);
  assign Err       = (state_q == S_FIN) && err_q;
  assign RData     = rdata_q;
  assign MemRead   = (state_q == S_RD) || (state_q == S_RMW_RD);
  assign MemWrite  = (state_q == S_WR) && !Reset;
  assign Address   = {2'b00, addr_q[31:2]};
  assign WriteData = (state_q != S_WR) ? 32'h0 :
                     (size_q == SZ_WORD) ? wdata_q : merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus hand-written sequences for
// reset-during-write and back-to-back requests with Req held high.
module tb_load_store_unit;

  localparam int MEM_WORDS = 128;
  localparam int NV = 20;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqSigned = 1'b0;
  logic [31:0] ReqAddr = 32'h0;
  logic [31:0] ReqWData = 32'h0;
  logic        Ready, Done, Err, MemRead, MemWrite;
  logic [31:0] RData, Address, WriteData, ReadData;

  logic [31:0] mem [0:MEM_WORDS-1];
  logic        pl_we = 1'b0;
  logic [6:0]  pl_idx = 7'd0;
  logic [31:0] pl_val = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
    .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .Ready(Ready), .Done(Done), .Err(Err), .RData(RData),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  // clock / reset block
  always #5 Clk = ~Clk;

  // memory model: combinational read, write on rising edge
  assign ReadData = (Address < MEM_WORDS) ? mem[Address[6:0]] : 32'h0;
  always @(posedge Clk) begin
    if (pl_we) mem[pl_idx] <= pl_val;
    else if (MemWrite && (Address < MEM_WORDS)) mem[Address[6:0]] <= WriteData;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic        chk_mem;
    int          mem_idx;
    logic [31:0] mem_val;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(logic wr, logic [1:0] size, logic sgn, logic [31:0] addr,
                              logic [31:0] wdata, logic exp_err, logic [31:0] exp_rdata,
                              int exp_lat, int exp_rd, int exp_wr, logic chk_mem,
                              int mem_idx, logic [31:0] mem_val);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.chk_mem = chk_mem;
    v.mem_idx = mem_idx; v.mem_val = mem_val;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(posedge Clk); #1;
    pl_we = 1'b1; pl_idx = idx[6:0]; pl_val = val;
    @(posedge Clk); #1;
    pl_we = 1'b0;
  endtask

  // driver: present one request for one cycle, then watch until Done (bounded)
  task automatic run_req(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int nrd, output int nwr,
                         output logic err, output logic [31:0] rdata, output bit both);
    @(posedge Clk); #1;
    Req = 1'b1; ReqWrite = wr; ReqSize = size; ReqSigned = sgn;
    ReqAddr = addr; ReqWData = wdata;
    @(posedge Clk); #1;
    Req = 1'b0;
    lat = 0; nrd = 0; nwr = 0; err = 1'b0; rdata = 32'h0; both = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (MemRead) nrd++;
      if (MemWrite) nwr++;
      if (MemRead && MemWrite) both = 1'b1;
      if (Done) begin
        lat = c; err = Err; rdata = RData;
        break;
      end
    end
  endtask

  initial begin
    int lat, nrd, nwr, d1, d2, ndone;
    logic err;
    logic [31:0] rdata;
    bit both, dropped, drop;

    // vector table: {request, expected err, rdata, latency, reads, writes, memory check}
    vt[0]  = mk(0, 2'b00, 1, 32'h16,  32'h0,        0, 32'hFFFF_FF99, 3, 1, 0, 0, 0,   32'h0);
    vt[1]  = mk(0, 2'b01, 0, 32'h14,  32'h0,        0, 32'h0000_AABB, 3, 1, 0, 0, 0,   32'h0);
    vt[2]  = mk(0, 2'b01, 1, 32'h16,  32'h0,        0, 32'hFFFF_8899, 3, 1, 0, 0, 0,   32'h0);
    vt[3]  = mk(0, 2'b10, 1, 32'h14,  32'h0,        0, 32'h8899_AABB, 3, 1, 0, 0, 0,   32'h0);
    vt[4]  = mk(0, 2'b00, 0, 32'h17,  32'h0,        0, 32'h0000_0088, 3, 1, 0, 0, 0,   32'h0);
    vt[5]  = mk(1, 2'b00, 0, 32'h15,  32'hFFFF_FF5A, 0, 32'h0000_0088, 4, 1, 1, 1, 5, 32'h8899_5ABB);
    vt[6]  = mk(0, 2'b10, 0, 32'h14,  32'h0,        0, 32'h8899_5ABB, 3, 1, 0, 0, 0,   32'h0);
    vt[7]  = mk(1, 2'b01, 0, 32'h1A,  32'h1234_CAFE, 0, 32'h8899_5ABB, 4, 1, 1, 1, 6, 32'hCAFE_3344);
    vt[8]  = mk(0, 2'b00, 1, 32'h18,  32'h0,        0, 32'h0000_0044, 3, 1, 0, 0, 0,   32'h0);
    vt[9]  = mk(1, 2'b10, 0, 32'h1C,  32'hDEAD_BEEF, 0, 32'h0000_0044, 3, 0, 1, 1, 7, 32'hDEAD_BEEF);
    vt[10] = mk(0, 2'b10, 0, 32'h1C,  32'h0,        0, 32'hDEAD_BEEF, 3, 1, 0, 0, 0,   32'h0);
    vt[11] = mk(0, 2'b10, 0, 32'h06,  32'h0,        1, 32'hDEAD_BEEF, 2, 0, 0, 0, 0,   32'h0);
    vt[12] = mk(0, 2'b01, 0, 32'h03,  32'h0,        1, 32'hDEAD_BEEF, 2, 0, 0, 0, 0,   32'h0);
    vt[13] = mk(0, 2'b10, 0, 32'h200, 32'h0,        1, 32'hDEAD_BEEF, 2, 0, 0, 0, 0,   32'h0);
    vt[14] = mk(0, 2'b11, 0, 32'h14,  32'h0,        1, 32'hDEAD_BEEF, 2, 0, 0, 0, 0,   32'h0);
    vt[15] = mk(1, 2'b01, 0, 32'h15,  32'h0000_1111, 1, 32'hDEAD_BEEF, 2, 0, 0, 1, 5, 32'h8899_5ABB);
    vt[16] = mk(0, 2'b00, 1, 32'h1FF, 32'h0,        0, 32'hFFFF_FFA5, 3, 1, 0, 0, 0,   32'h0);
    vt[17] = mk(1, 2'b00, 0, 32'h1FC, 32'h0000_0077, 0, 32'hFFFF_FFA5, 4, 1, 1, 1, 127, 32'hA500_0077);
    vt[18] = mk(0, 2'b01, 0, 32'h1FE, 32'h0,        0, 32'h0000_A500, 3, 1, 0, 0, 0,   32'h0);
    vt[19] = mk(1, 2'b10, 0, 32'h200, 32'h1234_5678, 1, 32'h0000_A500, 2, 0, 0, 1, 0, 32'h0);

    // reset, with memory preload while the unit is held in reset
    for (int i = 0; i < MEM_WORDS; i++) preload(i, 32'h0);
    preload(5, 32'h8899_AABB);
    preload(6, 32'h1122_3344);
    preload(8, 32'h0102_0304);
    preload(127, 32'hA500_0000);
    @(negedge Clk);
    chk("rst_ready", {31'h0, Ready}, 32'h1);
    chk("rst_done", {31'h0, Done}, 32'h0);
    chk("rst_err", {31'h0, Err}, 32'h0);
    chk("rst_rdata", RData, 32'h0);
    chk("rst_memrd", {31'h0, MemRead}, 32'h0);
    chk("rst_memwr", {31'h0, MemWrite}, 32'h0);
    chk("rst_addr", Address, 32'h0);
    chk("rst_wdata", WriteData, 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_req(vt[i].wr, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata,
              lat, nrd, nwr, err, rdata, both);
      chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vt[i].exp_err});
      chk($sformatf("v%0d_rdata", i), rdata, vt[i].exp_rdata);
      chk($sformatf("v%0d_memread_cycles", i), nrd, vt[i].exp_rd);
      chk($sformatf("v%0d_memwrite_cycles", i), nwr, vt[i].exp_wr);
      chk($sformatf("v%0d_strobe_overlap", i), {31'h0, both}, 32'h0);
      if (vt[i].chk_mem)
        chk($sformatf("v%0d_mem", i), mem[vt[i].mem_idx], vt[i].mem_val);
    end

    // reset asserted while a word store sits in WR
    @(posedge Clk); #1;
    Req = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqAddr = 32'h20; ReqWData = 32'hFFFF_FFFF;
    @(posedge Clk); #1;
    Req = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("rstwr_in_wr", {31'h0, MemWrite}, 32'h1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      if (Done) ndone++;
    end
    chk("rstwr_mem", mem[8], 32'h0102_0304);
    chk("rstwr_ready", {31'h0, Ready}, 32'h1);
    chk("rstwr_rdata", RData, 32'h0);
    chk("rstwr_no_done", ndone, 0);

    // back-to-back: Req held high; busy-time fields change and must be ignored
    @(posedge Clk); #1;
    Req = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqSigned = 1'b0;
    ReqAddr = 32'h24; ReqWData = 32'h1357_9BDF;
    @(posedge Clk); #1;
    ReqWrite = 1'b0; ReqWData = 32'h0;
    d1 = 0; d2 = 0; ndone = 0; nrd = 0; nwr = 0; dropped = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      drop = 1'b0;
      @(negedge Clk);
      if (MemRead) nrd++;
      if (MemWrite) nwr++;
      if (Done) begin
        ndone++;
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (Ready && !dropped) drop = 1'b1;
      @(posedge Clk); #1;
      if (drop) begin
        Req = 1'b0;
        dropped = 1'b1;
      end
    end
    chk("b2b_store_latency", d1, 3);
    chk("b2b_load_done_cycle", d2, 7);
    chk("b2b_done_count", ndone, 2);
    chk("b2b_memread_cycles", nrd, 1);
    chk("b2b_memwrite_cycles", nwr, 1);
    chk("b2b_mem", mem[9], 32'h1357_9BDF);
    chk("b2b_rdata", RData, 32'h1357_9BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
